uart_ctrl_arb: RTL

Controller for the CoreUART `UART` instance.
- Owns all CoreUART host-side pins and sequences the `CSN`/`WEN`/`OEN` strobes.
- Shares the transmitter between two byte requesters using round-robin.
- Drains received bytes, with error flags, onto a valid-pulse interface.
- Loads baud and framing configuration only while the UART is quiescent.

---
 rtl/uart_ctrl_arb.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_ctrl_arb.sv
// uart_ctrl_arb
// Host-side controller for a CoreUART instance. Owns the CSN/WEN/OEN strobes,
// shares the transmitter between two byte requesters with round-robin
// arbitration, drains received bytes (with error flags) onto a valid-pulse
// interface, and applies baud/framing configuration only while the UART is
// quiescent.
//
// Ports:
//   CLK, RESET_N               clock, asynchronous active-low reset
//   cfg_*, cfg_load            configuration values captured into a shadow
//   cfg_pending                shadow not yet applied to the UART
//   req{0,1}_valid/_data/_ready  TX requesters (valid/ready handshake)
//   rx_valid, rx_data, rx_err  received byte, {FRAMING, PARITY, OVERFLOW}
//   BAUD_VAL, BIT8, PARITY_EN, ODD_N_EVEN  CoreUART configuration
//   CSN, WEN, OEN, DATA_IN     CoreUART strobes (active low) and write data
//   TXRDY, RXRDY, DATA_OUT, PARITY_ERR, FRAMING_ERR, OVERFLOW  CoreUART status
module uart_ctrl_arb #(
    parameter logic [12:0] BAUD_DEFAULT = 13'd64,
    parameter int unsigned GUARD_CYC    = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [12:0] cfg_baud,
    input  logic        cfg_bit8,
    input  logic        cfg_parity_en,
    input  logic        cfg_odd_n_even,
    input  logic        cfg_load,
    output logic        cfg_pending,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rx_err,
    output logic [12:0] BAUD_VAL,
    output logic        BIT8,
    output logic        PARITY_EN,
    output logic        ODD_N_EVEN,
    output logic        CSN,
    output logic        WEN,
    output logic        OEN,
    output logic [7:0]  DATA_IN,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic [7:0]  DATA_OUT,
    input  logic        PARITY_ERR,
    input  logic        FRAMING_ERR,
    input  logic        OVERFLOW
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_WR, S_RD, S_RD_CAP, S_GUARD
    } state_e;

    typedef struct packed {
        logic [12:0] baud;
        logic        bit8;
        logic        parity_en;
        logic        odd_n_even;
    } cfg_t;

    localparam cfg_t       CFG_RESET  = '{baud: BAUD_DEFAULT, bit8: 1'b1,
                                          parity_en: 1'b0, odd_n_even: 1'b0};
    localparam logic [2:0] GUARD_LAST = 3'(GUARD_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  guard_cnt_q, guard_cnt_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        grant_q, grant_d;
    cfg_t        shadow_q, shadow_d;
    logic        cfg_pending_q, cfg_pending_d;
    cfg_t        cfg_q, cfg_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
    logic        req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [2:0]  rx_err_q, rx_err_d;
    logic        ptr_valid;

    // Pointer's own requester is valid; otherwise the other one wins.
    assign ptr_valid = rr_ptr_q ? req1_valid : req0_valid;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d       = state_q;
        guard_cnt_d   = guard_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        shadow_d      = shadow_q;
        cfg_pending_d = cfg_pending_q;
        cfg_d         = cfg_q;
        data_in_d     = data_in_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_err_d      = rx_err_q;

        // Shadow capture runs in every state; the last load wins.
        if (cfg_load) begin
            shadow_d      = '{baud: cfg_baud, bit8: cfg_bit8,
                              parity_en: cfg_parity_en, odd_n_even: cfg_odd_n_even};
            cfg_pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // A load arriving this cycle is already pending at the edge.
                if (cfg_pending_q || cfg_load) begin
                    state_d = S_CFG;
                end else if (RXRDY) begin
                    state_d = S_RD;
                end else if (TXRDY && (req0_valid || req1_valid)) begin
                    state_d   = S_WR;
                    grant_d   = ptr_valid ? rr_ptr_q : ~rr_ptr_q;
                    data_in_d = grant_d ? req1_data : req0_data;
                    rr_ptr_d  = ~grant_d;
                end
            end
            S_CFG: begin
                cfg_d         = shadow_q;
                // A load coinciding with the copy keeps the new value pending.
                cfg_pending_d = cfg_load;
                state_d       = S_GUARD;
                guard_cnt_d   = GUARD_LAST;
            end
            S_WR: begin
                state_d     = S_GUARD;
                guard_cnt_d = GUARD_LAST;
            end
            S_RD: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                rx_data_d   = DATA_OUT;
                rx_err_d    = {FRAMING_ERR, PARITY_ERR, OVERFLOW};
                rx_valid_d  = 1'b1;
                state_d     = S_GUARD;
                guard_cnt_d = GUARD_LAST;
            end
            S_GUARD: begin
                if (guard_cnt_q == 3'd0) state_d = S_IDLE;
                else                     guard_cnt_d = guard_cnt_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes and ready are decoded from the next state so they are
        // registered yet line up exactly with the state they belong to.
        csn_d        = !(state_d inside {S_WR, S_RD, S_RD_CAP});
        wen_d        = (state_d != S_WR);
        oen_d        = !(state_d inside {S_RD, S_RD_CAP});
        req0_ready_d = (state_d == S_WR) && !grant_d;
        req1_ready_d = (state_d == S_WR) &&  grant_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            guard_cnt_q   <= 3'd0;
            rr_ptr_q      <= 1'b0;
            grant_q       <= 1'b0;
            shadow_q      <= '0;
            cfg_pending_q <= 1'b0;
            cfg_q         <= CFG_RESET;
            data_in_q     <= 8'd0;
            csn_q         <= 1'b1;
            wen_q         <= 1'b1;
            oen_q         <= 1'b1;
            req0_ready_q  <= 1'b0;
            req1_ready_q  <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_err_q      <= 3'd0;
        end else begin
            state_q       <= state_d;
            guard_cnt_q   <= guard_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            shadow_q      <= shadow_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_q         <= cfg_d;
            data_in_q     <= data_in_d;
            csn_q         <= csn_d;
            wen_q         <= wen_d;
            oen_q         <= oen_d;
            req0_ready_q  <= req0_ready_d;
            req1_ready_q  <= req1_ready_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_err_q      <= rx_err_d;
        end
    end

    assign cfg_pending = cfg_pending_q;
    assign BAUD_VAL    = cfg_q.baud;
    assign BIT8        = cfg_q.bit8;
    assign PARITY_EN   = cfg_q.parity_en;
    assign ODD_N_EVEN  = cfg_q.odd_n_even;
    assign DATA_IN     = data_in_q;
    assign CSN         = csn_q;
    assign WEN         = wen_q;
    assign OEN         = oen_q;
    assign req0_ready  = req0_ready_q;
    assign req1_ready  = req1_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_err      = rx_err_q;

endmodule
